// File: rtl/mem_readout_merge.sv
// mem_readout_merge: drains up to NCH per-event memories (1-cycle read latency)
// into one tagged stream {bx, channel, word} through a 2-entry output FIFO,
// with fixed-priority or round-robin arbitration and valid/ready backpressure.
module mem_readout_merge #(
  parameter int NCH = 12,
  parameter int DW  = 54,
  parameter int AW  = 6,
  parameter int BXW = 3,
  parameter int RR  = 0,
  localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1,
  localparam int OW  = BXW + CHW + DW
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [BXW-1:0]    bx,
  input  logic [NCH*AW-1:0] number_in,
  output logic [NCH*AW-1:0] read_add,
  input  logic [NCH*DW-1:0] mem_dat,
  output logic [OW-1:0]     out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP1,
    S_SETUP2,
    S_RUN,
    S_DONE
  } state_e;

  state_e          state_q;
  logic [BXW-1:0]  bx_q;
  logic [AW-1:0]   cnt_q  [NCH];
  logic [AW-1:0]   addr_q [NCH];
  logic [CHW-1:0]  sel_q;
  logic [CHW-1:0]  ptr_q;
  logic            inflight_q;
  logic [OW-1:0]   fifo_q [2];
  logic            wr_ptr_q;
  logic            rd_ptr_q;
  logic [1:0]      occ_q;
  logic            done_q;

  logic [NCH-1:0]  req;
  logic            found_lo;
  logic            found_hi;
  logic [CHW-1:0]  idx_lo;
  logic [CHW-1:0]  idx_hi;
  logic            grant_found;
  logic [CHW-1:0]  grant_idx;
  logic            pop;
  logic            push;
  logic            space_ok;
  logic            do_grant;
  logic            run_done;
  logic [OW-1:0]   push_word;

  // Requests and arbitration: lowest requester overall, and lowest requester
  // above the round-robin pointer (the wrap-around case falls back to lowest).
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    req      = '0;
    found_lo = 1'b0;
    found_hi = 1'b0;
    idx_lo   = '0;
    idx_hi   = '0;
    for (int i = 0; i < NCH; i++) begin
      req[i] = (cnt_q[i] != '0);
    end
    for (int i = 0; i < NCH; i++) begin
      if (req[i] && !found_lo) begin
        found_lo = 1'b1;
        idx_lo   = CHW'(i);
      end
      if (req[i] && !found_hi && (CHW'(i) > ptr_q)) begin
        found_hi = 1'b1;
        idx_hi   = CHW'(i);
      end
    end
    grant_found = found_lo;
    grant_idx   = ((RR != 0) && found_hi) ? idx_hi : idx_lo;
  end

  // A grant is only issued when the word it produces is guaranteed a FIFO slot.
  assign pop       = (occ_q != 2'd0) && out_ready;
  assign push      = inflight_q;
  assign space_ok  = (({1'b0, occ_q} + {2'b00, inflight_q}) <= (3'd1 + {2'b00, pop}));
  assign do_grant  = (state_q == S_RUN) && grant_found && space_ok;
  assign run_done  = (req == '0) && !inflight_q && (occ_q == {1'b0, pop});
  assign push_word = {bx_q, sel_q, mem_dat[int'(sel_q)*DW +: DW]};

  // Read addresses come straight from the address registers.
  always_comb begin
    read_add = '0;
    for (int i = 0; i < NCH; i++) begin
      read_add[i*AW +: AW] = addr_q[i];
    end
  end

  assign out_data  = fifo_q[rd_ptr_q];
  assign out_valid = (occ_q != 2'd0);
  assign done      = done_q;

  // Sequencer, per-channel counters, grant pipeline and output FIFO.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      bx_q       <= '0;
      sel_q      <= '0;
      ptr_q      <= CHW'(NCH - 1);
      inflight_q <= 1'b0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      occ_q      <= 2'd0;
      done_q     <= 1'b0;
      for (int i = 0; i < NCH; i++) begin
        cnt_q[i]  <= '0;
        addr_q[i] <= '0;
      end
      // NOTE: the two FIFO entries are reset because out_data must read zero
      // out of reset; a deeper storage array would normally be left unreset.
      fifo_q[0] <= '0;
      fifo_q[1] <= '0;
    end else if (start) begin
      // NOTE: sequential state is always updated with non-blocking assignments
      // so every register samples the pre-edge values of the others.
      state_q    <= S_SETUP1;
      bx_q       <= bx;
      ptr_q      <= CHW'(NCH - 1);
      inflight_q <= 1'b0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      occ_q      <= 2'd0;
      done_q     <= 1'b0;
      for (int i = 0; i < NCH; i++) begin
        cnt_q[i]  <= number_in[i*AW +: AW];
        addr_q[i] <= '0;
      end
    end else begin
      case (state_q)
        S_SETUP1: state_q <= S_SETUP2;
        S_SETUP2: state_q <= S_RUN;
        S_RUN: begin
          if (run_done) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end
        end
        default: ;
      endcase

      inflight_q <= do_grant;
      if (do_grant) begin
        addr_q[grant_idx] <= addr_q[grant_idx] + AW'(1);
        cnt_q[grant_idx]  <= cnt_q[grant_idx] - AW'(1);
        sel_q             <= grant_idx;
        ptr_q             <= grant_idx;
      end

      if (push) begin
        fifo_q[wr_ptr_q] <= push_word;
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      occ_q <= occ_q + {1'b0, push} - {1'b0, pop};
    end
  end

endmodule

// File: tb/tb_mem_readout_merge.sv
// Bench for mem_readout_merge: a fixed-priority and a round-robin instance share
// the stimulus; a memory model feeds each, and a per-instance scoreboard queue
// holds the words expected in order.
module tb_mem_readout_merge;

  localparam int NCH = 12;
  localparam int DW  = 54;
  localparam int AW  = 6;
  localparam int BXW = 3;
  localparam int CHW = 4;
  localparam int OW  = BXW + CHW + DW;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic              out_ready;
  logic [BXW-1:0]    bx;
  logic [NCH*AW-1:0] number_in;

  logic [NCH*AW-1:0] read_add_fp, read_add_rr;
  logic [NCH*DW-1:0] mem_dat_fp, mem_dat_rr;
  logic [OW-1:0]     out_data_fp, out_data_rr;
  logic              out_valid_fp, out_valid_rr;
  logic              done_fp, done_rr;

  mem_readout_merge #(.NCH(NCH), .DW(DW), .AW(AW), .BXW(BXW), .RR(0)) u_dut_fp (
    .clk(clk), .reset(reset), .start(start), .bx(bx), .number_in(number_in),
    .read_add(read_add_fp), .mem_dat(mem_dat_fp), .out_data(out_data_fp),
    .out_valid(out_valid_fp), .out_ready(out_ready), .done(done_fp)
  );

  mem_readout_merge #(.NCH(NCH), .DW(DW), .AW(AW), .BXW(BXW), .RR(1)) u_dut_rr (
    .clk(clk), .reset(reset), .start(start), .bx(bx), .number_in(number_in),
    .read_add(read_add_rr), .mem_dat(mem_dat_rr), .out_data(out_data_rr),
    .out_valid(out_valid_rr), .out_ready(out_ready), .done(done_rr)
  );

  always #5 clk = ~clk;

  // Memory contents: a per-event salt, the channel and the address.
  logic [23:0] salt = 24'h0;
  function automatic logic [DW-1:0] word_of(int ch, int a);
    return {salt, 14'(ch), 16'(a)};
  endfunction

  // Synchronous memories, one-cycle read latency.
  always @(posedge clk) begin
    for (int i = 0; i < NCH; i++) begin
      mem_dat_fp[i*DW +: DW] <= word_of(i, int'(read_add_fp[i*AW +: AW]));
      mem_dat_rr[i*DW +: DW] <= word_of(i, int'(read_add_rr[i*AW +: AW]));
    end
  end

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int cnt_cfg [NCH];
  logic [OW-1:0] qa[$];
  logic [OW-1:0] qb[$];
  bit   mon_en = 1'b1;
  int   first_pop [2];
  int   last_pop [2];
  int   done_cyc [2];
  int   pops [2];
  bit   stall_q [2];
  logic [OW-1:0] held_q [2];
  int   max_addr3;

  task automatic check(string tag, logic [127:0] obs, logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_track();
    for (int d = 0; d < 2; d++) begin
      first_pop[d] = -1;
      last_pop[d]  = -1;
      done_cyc[d]  = -1;
      pops[d]      = 0;
      stall_q[d]   = 1'b0;
    end
    max_addr3 = 0;
  endtask

  // Per-cycle observation of one instance: hold during stall, scoreboard pop.
  task automatic mon_one(int d, logic v, logic [OW-1:0] data, logic dn);
    string t;
    logic [OW-1:0] exp_w;
    t = (d == 0) ? "fp" : "rr";
    if (mon_en) begin
      if (stall_q[d]) check({t, "_hold"}, {v, data}, {1'b1, held_q[d]});
      if (v && out_ready) begin
        exp_w = 'x;
        if (d == 0 && qa.size() != 0) exp_w = qa.pop_front();
        if (d == 1 && qb.size() != 0) exp_w = qb.pop_front();
        check({t, "_word"}, data, exp_w);
        pops[d]++;
        if (first_pop[d] < 0) first_pop[d] = cyc;
        last_pop[d] = cyc;
      end
      if (dn && done_cyc[d] < 0) done_cyc[d] = cyc;
    end
    stall_q[d] = v && !out_ready;
    held_q[d]  = data;
  endtask

  // One clock: observe at the falling edge, return 1 time unit after rising.
  task automatic tick();
    @(negedge clk);
    mon_one(0, out_valid_fp, out_data_fp, done_fp);
    mon_one(1, out_valid_rr, out_data_rr, done_rr);
    if (int'(read_add_fp[3*AW +: AW]) > max_addr3) max_addr3 = int'(read_add_fp[3*AW +: AW]);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic clear_cfg();
    for (int i = 0; i < NCH; i++) cnt_cfg[i] = 0;
  endtask

  function automatic int total_items();
    int s = 0;
    for (int i = 0; i < NCH; i++) s += cnt_cfg[i];
    return s;
  endfunction

  // Reference ordering for both arbitration modes, pushed at stimulus time.
  task automatic build_expect(logic [BXW-1:0] b);
    int rem [NCH];
    int adr [NCH];
    int ptr;
    int g;
    int idx;
    logic [OW-1:0] w;
    for (int m = 0; m < 2; m++) begin
      ptr = NCH - 1;
      for (int i = 0; i < NCH; i++) begin
        rem[i] = cnt_cfg[i];
        adr[i] = 0;
      end
      g = 0;
      while (g >= 0) begin
        g = -1;
        if (m == 0) begin
          for (int i = 0; i < NCH; i++) if (g < 0 && rem[i] > 0) g = i;
        end else begin
          for (int k = 1; k <= NCH; k++) begin
            idx = (ptr + k) % NCH;
            if (g < 0 && rem[idx] > 0) g = idx;
          end
        end
        if (g >= 0) begin
          w = {b, CHW'(g), word_of(g, adr[g])};
          if (m == 0) qa.push_back(w);
          else        qb.push_back(w);
          adr[g]++;
          rem[g]--;
          ptr = g;
        end
      end
    end
  endtask

  // Pulse start through edge E0; returns during cycle 1 with fresh expectations.
  task automatic start_event(logic [BXW-1:0] b, logic [23:0] s);
    salt = s;
    bx   = b;
    for (int i = 0; i < NCH; i++) number_in[i*AW +: AW] = AW'(cnt_cfg[i]);
    start  = 1'b1;
    mon_en = 1'b0;
    tick();
    mon_en = 1'b1;
    start  = 1'b0;
    cyc    = 1;
    qa.delete();
    qb.delete();
    clear_track();
    build_expect(b);
  endtask

  task automatic run_to_done(int budget, bit rnd);
    int n = 0;
    while (!(done_cyc[0] >= 0 && done_cyc[1] >= 0) && n < budget) begin
      if (rnd) out_ready = 1'($urandom_range(0, 1));
      tick();
      n++;
    end
    out_ready = 1'b1;
    check("done_within_budget", {done_cyc[0] >= 0, done_cyc[1] >= 0}, 2'b11);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b0;
    start     = 1'b0;
    out_ready = 1'b1;
    bx        = '0;
    number_in = '0;
    clear_cfg();
    clear_track();

    // Reset values.
    #1;
    check("rst_valid", out_valid_fp, 1'b0);
    check("rst_data", out_data_fp, '0);
    check("rst_done", done_fp, 1'b0);
    check("rst_read_add", read_add_fp, '0);
    check("rst_rr_valid", out_valid_rr, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    tick();
    tick();
    check("idle_valid", out_valid_fp, 1'b0);
    check("idle_done", done_fp, 1'b0);

    // ch0 = 3, ch11 = 2, ready held high.
    clear_cfg();
    cnt_cfg[0]  = 3;
    cnt_cfg[11] = 2;
    start_event(3'd5, 24'h111111);
    run_to_done(100, 1'b0);
    check("s1_first_word_cycle", first_pop[0], 5);
    check("s1_last_word_cycle", last_pop[0], 9);
    check("s1_done_cycle", done_cyc[0], 10);
    check("s1_rr_done_cycle", done_cyc[1], 10);
    check("s1_fp_drained", qa.size(), 0);
    check("s1_rr_drained", qb.size(), 0);

    // ch0..ch2 = 2 each: interleaved under round robin, grouped under fixed.
    clear_cfg();
    cnt_cfg[0] = 2;
    cnt_cfg[1] = 2;
    cnt_cfg[2] = 2;
    start_event(3'd2, 24'h222222);
    run_to_done(100, 1'b0);
    check("s2_fp_pops", pops[0], 6);
    check("s2_rr_pops", pops[1], 6);
    check("s2_done_cycle", done_cyc[0], 5 + total_items());
    check("s2_rr_drained", qb.size(), 0);

    // All counts zero.
    clear_cfg();
    start_event(3'd3, 24'h333333);
    run_to_done(50, 1'b0);
    check("s3_fp_done_cycle", done_cyc[0], 4);
    check("s3_rr_done_cycle", done_cyc[1], 4);
    check("s3_no_words", pops[0] + pops[1], 0);

    // ch3 = 10 with random backpressure.
    clear_cfg();
    cnt_cfg[3] = 10;
    start_event(3'd4, 24'h444444);
    run_to_done(400, 1'b1);
    check("s4_fp_pops", pops[0], 10);
    check("s4_rr_pops", pops[1], 10);
    check("s4_read_add_max", max_addr3, 10);
    check("s4_fp_drained", qa.size(), 0);

    // Restart after 4 of 20 words.
    clear_cfg();
    cnt_cfg[5] = 20;
    start_event(3'd1, 24'h555555);
    begin
      int n = 0;
      while (pops[0] < 4 && n < 50) begin
        tick();
        n++;
      end
    end
    check("s5_pops_before_restart", pops[0], 4);
    start_event(3'd6, 24'h666666);
    check("s5_restart_valid_fp", out_valid_fp, 1'b0);
    check("s5_restart_valid_rr", out_valid_rr, 1'b0);
    check("s5_restart_addr", read_add_fp[5*AW +: AW], '0);
    run_to_done(100, 1'b0);
    check("s5_first_word_cycle", first_pop[0], 5);
    check("s5_pops", pops[0], 20);
    check("s5_done_cycle", done_cyc[0], 25);
    check("s5_fp_drained", qa.size(), 0);

    // Reset mid-run, with a start attempt during reset.
    clear_cfg();
    cnt_cfg[7] = 6;
    start_event(3'd4, 24'h777777);
    repeat (5) tick();
    check("s6_valid_before_reset", out_valid_fp, 1'b1);
    reset = 1'b0;
    start = 1'b1;
    #1;
    check("s6_rst_valid", out_valid_fp, 1'b0);
    check("s6_rst_data", out_data_fp, '0);
    check("s6_rst_done", done_fp, 1'b0);
    check("s6_rst_read_add", read_add_fp, '0);
    check("s6_rst_rr_valid", out_valid_rr, 1'b0);
    qa.delete();
    qb.delete();
    clear_track();
    tick();
    tick();
    start = 1'b0;
    reset = 1'b1;
    repeat (8) tick();
    check("s6_idle_pops", pops[0] + pops[1], 0);
    check("s6_idle_done", done_cyc[0], -1);
    check("s6_idle_read_add", read_add_fp, '0);

    // Recovery: a single word after reset.
    clear_cfg();
    cnt_cfg[2] = 1;
    start_event(3'd7, 24'h888888);
    run_to_done(50, 1'b0);
    check("s7_first_word_cycle", first_pop[0], 5);
    check("s7_done_cycle", done_cyc[0], 6);
    check("s7_rr_drained", qb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
